// File: rtl/pwm_compare_dt_nch_pkg.sv
// Shared types and default widths for the carrier-compare PWM stage with dead-time insertion.
package pwm_compare_dt_nch_pkg;

  localparam int unsigned DefNch      = 4;
  localparam int unsigned DefPwmWidth = 16;
  localparam int unsigned DefDtWidth  = 10;

  typedef enum logic [2:0] {
    StIdle,
    StAOn,
    StDtToB,
    StBOn,
    StDtToA
  } ch_state_e;

endpackage

// File: rtl/pwm_compare_dt_nch_channel.sv
// One PWM channel: shadowed compare, registered carrier compare and the A/B dead-time FSM.
module pwm_compare_dt_nch_channel
  import pwm_compare_dt_nch_pkg::*;
#(
  parameter int unsigned PWMWIDTH = DefPwmWidth,
  parameter int unsigned DTWIDTH  = DefDtWidth
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                ce,
  input  logic [PWMWIDTH-1:0] carrier,
  input  logic                load_evt,
  input  logic [PWMWIDTH-1:0] compare,
  input  logic                compare_wr,
  input  logic                sig_pwm,
  input  logic                halt,
  input  logic [DTWIDTH-1:0]  dead_time,
  output logic                pwm_a,
  output logic                pwm_b,
  output logic                pending
);

  logic [PWMWIDTH-1:0] shadow_q, active_q;
  logic                pending_q, raw_q;
  logic [DTWIDTH-1:0]  cnt_q;
  logic                a_q, b_q;
  ch_state_e           state_q;
  logic                xfer;

  assign xfer = load_evt & ce & pending_q;

  // Transfer always takes the pre-write shadow; a concurrent write stays pending.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      raw_q     <= 1'b0;
    end else begin
      raw_q <= (carrier <= active_q) ^ sig_pwm;
      if (xfer) begin
        active_q  <= shadow_q;
        pending_q <= 1'b0;
      end
      if (compare_wr) begin
        shadow_q  <= compare;
        pending_q <= 1'b1;
      end
    end
  end

  // A zero dead time enters the target ON state directly; otherwise the gap counts down on ce.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else if (halt) begin
      state_q <= StIdle;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StAOn, StBOn: begin
          if ((state_q == StIdle) || (state_q == StAOn && !raw_q) ||
              (state_q == StBOn && raw_q)) begin
            a_q <= 1'b0;
            b_q <= 1'b0;
            cnt_q <= dead_time;
            if (dead_time == '0) begin
              state_q <= raw_q ? StAOn : StBOn;
              a_q     <= raw_q;
              b_q     <= !raw_q;
            end else begin
              state_q <= raw_q ? StDtToA : StDtToB;
            end
          end
        end
        StDtToA, StDtToB: begin
          if (raw_q != (state_q == StDtToA)) begin
            cnt_q <= dead_time;
            if (dead_time == '0) begin
              state_q <= raw_q ? StAOn : StBOn;
              a_q     <= raw_q;
              b_q     <= !raw_q;
            end else begin
              state_q <= raw_q ? StDtToA : StDtToB;
            end
          end else if (ce) begin
            if (cnt_q <= DTWIDTH'(1)) begin
              state_q <= raw_q ? StAOn : StBOn;
              a_q     <= raw_q;
              b_q     <= !raw_q;
            end else begin
              cnt_q <= cnt_q - DTWIDTH'(1);
            end
          end
        end
        default: begin
          state_q <= StIdle;
          a_q     <= 1'b0;
          b_q     <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_a   = a_q;
  assign pwm_b   = b_q;
  assign pending = pending_q;

endmodule

// File: rtl/pwm_compare_dt_nch.sv
// N-channel carrier-compare PWM with complementary dead-time outputs and latched trip protection.
module pwm_compare_dt_nch
  import pwm_compare_dt_nch_pkg::*;
#(
  parameter int unsigned NCH      = DefNch,
  parameter int unsigned PWMWIDTH = DefPwmWidth,
  parameter int unsigned DTWIDTH  = DefDtWidth
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    ce,
  input  logic [PWMWIDTH-1:0]     carrier,
  input  logic                    load_evt,
  input  logic [NCH*PWMWIDTH-1:0] compare,
  input  logic [NCH-1:0]          compare_wr,
  input  logic [NCH-1:0]          sig_pwm,
  input  logic                    en_pwm,
  input  logic [DTWIDTH-1:0]      dead_time,
  input  logic                    trip,
  input  logic                    trip_clr,
  output logic [NCH-1:0]          pwm_a,
  output logic [NCH-1:0]          pwm_b,
  output logic [NCH-1:0]          pending,
  output logic                    fault
);

  logic fault_q;
  logic halt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fault_q <= 1'b0;
    end else if (trip) begin
      fault_q <= 1'b1;
    end else if (trip_clr) begin
      fault_q <= 1'b0;
    end
  end

  // Raw trip is included so outputs drop on the same edge that latches the fault.
  assign halt  = !en_pwm | fault_q | trip;
  assign fault = fault_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_compare_dt_nch_channel #(
      .PWMWIDTH (PWMWIDTH),
      .DTWIDTH  (DTWIDTH)
    ) u_ch (
      .clk        (clk),
      .rstn       (rstn),
      .ce         (ce),
      .carrier    (carrier),
      .load_evt   (load_evt),
      .compare    (compare[i*PWMWIDTH +: PWMWIDTH]),
      .compare_wr (compare_wr[i]),
      .sig_pwm    (sig_pwm[i]),
      .halt       (halt),
      .dead_time  (dead_time),
      .pwm_a      (pwm_a[i]),
      .pwm_b      (pwm_b[i]),
      .pending    (pending[i])
    );
  end

endmodule

// File: tb/tb_pwm_compare_dt_nch.sv
// Random-stimulus bench for pwm_compare_dt_nch against a target/gap reference model.
module tb_pwm_compare_dt_nch;

  localparam int NCH = 4;
  localparam int PW  = 8;
  localparam int DW  = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              ce, load_evt, en_pwm, trip, trip_clr;
  logic [PW-1:0]     carrier;
  logic [NCH*PW-1:0] compare;
  logic [NCH-1:0]    compare_wr, sig_pwm;
  logic [DW-1:0]     dead_time;
  logic [NCH-1:0]    pwm_a, pwm_b, pending;
  logic              fault;

  int total = 0;
  int bad   = 0;

  // Model: each channel has a target side and a remaining gap in ce-cycles before it turns on.
  int unsigned m_shadow [NCH];
  int unsigned m_active [NCH];
  bit          m_pend   [NCH];
  bit          m_rawq   [NCH];
  bit          m_valid  [NCH];
  bit          m_tgt    [NCH];
  bit          m_on     [NCH];
  int          m_gap    [NCH];
  bit          m_fault;

  always #5 clk = ~clk;

  pwm_compare_dt_nch #(
    .NCH      (NCH),
    .PWMWIDTH (PW),
    .DTWIDTH  (DW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ce         (ce),
    .carrier    (carrier),
    .load_evt   (load_evt),
    .compare    (compare),
    .compare_wr (compare_wr),
    .sig_pwm    (sig_pwm),
    .en_pwm     (en_pwm),
    .dead_time  (dead_time),
    .trip       (trip),
    .trip_clr   (trip_clr),
    .pwm_a      (pwm_a),
    .pwm_b      (pwm_b),
    .pending    (pending),
    .fault      (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_shadow[i] = 0; m_active[i] = 0; m_pend[i] = 0; m_rawq[i] = 0;
      m_valid[i] = 0; m_tgt[i] = 0; m_on[i] = 0; m_gap[i] = 0;
    end
    m_fault = 0;
  endtask

  task automatic model_step();
    bit halt;
    bit r;
    int unsigned cmp;
    halt = !en_pwm || m_fault || trip;
    for (int i = 0; i < NCH; i++) begin
      r = m_rawq[i];
      if (halt) begin
        m_valid[i] = 0; m_on[i] = 0;
      end else if (!m_valid[i] || r != m_tgt[i]) begin
        m_valid[i] = 1; m_tgt[i] = r; m_gap[i] = int'(dead_time); m_on[i] = (dead_time == 0);
      end else if (!m_on[i] && ce) begin
        m_gap[i]--;
        if (m_gap[i] <= 0) m_on[i] = 1;
      end
      m_rawq[i] = (int'(carrier) <= m_active[i]) ^ sig_pwm[i];
      if (load_evt && ce && m_pend[i]) begin
        m_active[i] = m_shadow[i];
        m_pend[i]   = 0;
      end
      if (compare_wr[i]) begin
        cmp = compare[i*PW +: PW];
        m_shadow[i] = cmp;
        m_pend[i]   = 1;
      end
    end
    if (trip) m_fault = 1;
    else if (trip_clr) m_fault = 0;
  endtask

  function automatic logic [NCH-1:0] exp_a();
    for (int i = 0; i < NCH; i++) exp_a[i] = m_valid[i] && m_on[i] && m_tgt[i];
  endfunction

  function automatic logic [NCH-1:0] exp_b();
    for (int i = 0; i < NCH; i++) exp_b[i] = m_valid[i] && m_on[i] && !m_tgt[i];
  endfunction

  function automatic logic [NCH-1:0] exp_pend();
    for (int i = 0; i < NCH; i++) exp_pend[i] = m_pend[i];
  endfunction

  task automatic check_all(input string phase);
    check({phase, "_pwm_a"}, 32'(pwm_a), 32'(exp_a()));
    check({phase, "_pwm_b"}, 32'(pwm_b), 32'(exp_b()));
    check({phase, "_pending"}, 32'(pending), 32'(exp_pend()));
    check({phase, "_fault"}, 32'(fault), 32'(m_fault));
    check({phase, "_overlap"}, 32'(|(pwm_a & pwm_b)), 32'd0);
  endtask

  initial begin
    int unsigned step;
    ce = 1'b1; load_evt = 1'b0; en_pwm = 1'b1; trip = 1'b0; trip_clr = 1'b0;
    carrier = '0; compare = '0; compare_wr = '0; sig_pwm = '0; dead_time = DW'(3);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rstn = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      if (rstn) model_step();
      else model_reset();
      #1;
      check_all(c < 1000 ? "ce_on" : "ce_rand");

      step = $urandom_range(1, 8);
      if (int'(carrier) + int'(step) > 255) carrier = '0;
      else carrier = carrier + PW'(step);
      load_evt = (carrier == '0);
      for (int i = 0; i < NCH; i++) begin
        compare_wr[i] = ($urandom_range(0, 15) == 0);
        compare[i*PW +: PW] = PW'($urandom_range(0, 255));
      end
      ce = (c < 1000) ? 1'b1 : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) dead_time = DW'($urandom_range(0, 9));
      if ($urandom_range(0, 199) == 0) sig_pwm = NCH'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) en_pwm = ~en_pwm;
      trip     = ($urandom_range(0, 399) == 0);
      trip_clr = ($urandom_range(0, 39) == 0);

      if (c == 2500) begin
        rstn = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
      end
      if (c == 2503) rstn = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
